// File: rtl/iob_uart16550_cfg_seq_pkg.sv
// Shared constants for the UART configuration sequencer.
// Holds the UART CSR byte offsets, the step encodings and the FSM state type.
// The register offsets match the ones used by the UART core and its drivers.
package iob_uart16550_cfg_seq_pkg;

  // UART CSR byte offsets
  localparam logic [2:0] RBR_THR_DLL = 3'd0;
  localparam logic [2:0] IER_DLM     = 3'd1;
  localparam logic [2:0] IIR_FCR     = 3'd2;
  localparam logic [2:0] LCR         = 3'd3;
  localparam int         LCR_DLAB    = 7;

  // Sequence steps, issued in this order
  localparam logic [2:0] STEP_W_LCR_DLAB = 3'd0;
  localparam logic [2:0] STEP_W_DLL      = 3'd1;
  localparam logic [2:0] STEP_W_DLM      = 3'd2;
  localparam logic [2:0] STEP_W_LCR      = 3'd3;
  localparam logic [2:0] STEP_W_FCR      = 3'd4;
  localparam logic [2:0] STEP_W_IER      = 3'd5;
  localparam logic [2:0] STEP_R_LCR      = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RWAIT,
    ST_FIN
  } state_t;

  // CSR byte offset targeted by a step
  function automatic logic [2:0] step_offset(input logic [2:0] step);
    logic [2:0] off;
    case (step)
      STEP_W_LCR_DLAB: off = LCR;
      STEP_W_DLL:      off = RBR_THR_DLL;
      STEP_W_DLM:      off = IER_DLM;
      STEP_W_LCR:      off = LCR;
      STEP_W_FCR:      off = IIR_FCR;
      STEP_W_IER:      off = IER_DLM;
      STEP_R_LCR:      off = LCR;
      default:         off = RBR_THR_DLL;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/iob_uart16550_cfg_seq_if.sv
// IOb CSR bus between the configuration sequencer (manager) and the UART.
// No latency of its own; plain wires.
// Request holds while valid=1 and ready=0; read data returns on rvalid.
interface iob_uart16550_cfg_seq_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic                valid;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                ready;

  modport master (output valid, addr, wdata, wstrb, input rvalid, rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rvalid, rdata, ready);
endinterface

// File: rtl/iob_uart16550_cfg_seq_timeout_cnt.sv
// Per-phase wait counter with clear, enable and a terminal-count flag.
// last_o is combinational from the count: high one increment before all-ones.
// No backpressure; the owner decides when to count and when to clear.
module iob_timeout_cnt #(
  parameter int TO_W = 8
) (
  input  logic clk_i,
  input  logic cke_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  logic [TO_W-1:0] cnt_q;

  // Count waiting cycles, saturating at all-ones; clear wins over count
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (cke_i) begin
      if (clr_i) begin
        cnt_q <= '0;
      end else if (en_i && (cnt_q != {TO_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Flag the owner so it can leave on the same edge the count saturates
  assign last_o = (cnt_q == {{(TO_W-1){1'b1}}, 1'b0});

endmodule

// File: rtl/iob_uart16550_cfg_seq.sv
// Brings up one UART16550: writes DLAB/DLL/DLM/LCR/FCR/IER, then reads LCR back.
// Start to done is 9 cycles with ready always high and rvalid one cycle after the read.
// Each request holds until ready; a phase that waits 2^TO_W-1 cycles aborts with err_o.
module iob_uart16550_cfg_seq
  import iob_uart16550_cfg_seq_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int TO_W   = 8
) (
  input  logic        clk_i,
  input  logic        cke_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [15:0] div_i,
  input  logic [7:0]  lcr_i,
  input  logic [7:0]  fcr_i,
  input  logic [7:0]  ier_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  iob_uart16550_cfg_seq_if.master bus
);

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic        err_q, err_d;
  logic        cap_en;
  logic [15:0] div_q;
  logic [7:0]  lcr_q, fcr_q, ier_q;
  logic        to_clr, to_en, to_last;
  logic [2:0]  off;
  logic        is_read;
  logic [7:0]  wr_byte;
  logic [7:0]  rd_byte;
  logic        unused_rdata;

  // Lane selection: LCR sits on byte lane 3 of the 32-bit bus
  assign rd_byte      = bus.rdata[{LCR[1:0], 3'b000} +: 8];
  assign unused_rdata = ^bus.rdata[23:0];

  // FSM, step and sticky error registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_W_LCR_DLAB;
      err_q   <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  // Configuration values are frozen at the accepted start
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_q <= '0;
      lcr_q <= '0;
      fcr_q <= '0;
      ier_q <= '0;
    end else if (cke_i && cap_en) begin
      div_q <= div_i;
      lcr_q <= lcr_i;
      fcr_q <= fcr_i;
      ier_q <= ier_i;
    end
  end

  // Byte written by the current step
  always_comb begin
    off     = step_offset(step_q);
    is_read = (step_q == STEP_R_LCR);
    wr_byte = 8'h00;
    case (step_q)
      STEP_W_LCR_DLAB: begin
        wr_byte           = lcr_q;
        wr_byte[LCR_DLAB] = 1'b1;
      end
      STEP_W_DLL: wr_byte = div_q[7:0];
      STEP_W_DLM: wr_byte = div_q[15:8];
      STEP_W_LCR: begin
        wr_byte           = lcr_q;
        wr_byte[LCR_DLAB] = 1'b0;
      end
      STEP_W_FCR: wr_byte = fcr_q;
      STEP_W_IER: wr_byte = ier_q;
      default:    wr_byte = 8'h00;
    endcase
  end

  // Next state: back-to-back writes, one read, then a one-cycle terminal state
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    err_d   = err_q;
    cap_en  = 1'b0;
    to_clr  = 1'b0;
    to_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        to_clr = 1'b1;
        if (start_i) begin
          state_d = ST_REQ;
          step_d  = STEP_W_LCR_DLAB;
          err_d   = 1'b0;
          cap_en  = 1'b1;
        end
      end
      ST_REQ: begin
        if (bus.ready) begin
          to_clr = 1'b1;
          if (is_read) begin
            state_d = ST_RWAIT;
          end else begin
            step_d = step_q + 3'd1;
          end
        end else begin
          to_en = 1'b1;
          if (to_last) begin
            state_d = ST_FIN;
            err_d   = 1'b1;
          end
        end
      end
      ST_RWAIT: begin
        if (bus.rvalid) begin
          state_d = ST_FIN;
          if (rd_byte != {1'b0, lcr_q[6:0]}) begin
            err_d = 1'b1;
          end
        end else begin
          to_en = 1'b1;
          if (to_last) begin
            state_d = ST_FIN;
            err_d   = 1'b1;
          end
        end
      end
      ST_FIN: begin
        to_clr  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  iob_timeout_cnt #(
    .TO_W(TO_W)
  ) u_timeout (
    .clk_i  (clk_i),
    .cke_i  (cke_i),
    .rst_n_i(rst_n_i),
    .clr_i  (to_clr),
    .en_i   (to_en),
    .last_o (to_last)
  );

  assign bus.valid = (state_q == ST_REQ);
  assign bus.addr  = bus.valid ? ADDR_W'(off) : '0;
  assign bus.wstrb = (bus.valid && !is_read) ? ((DATA_W/8)'(1) << off[1:0]) : '0;
  assign bus.wdata = (bus.valid && !is_read) ? {(DATA_W/8){wr_byte}} : '0;

  assign busy_o = (state_q == ST_REQ) || (state_q == ST_RWAIT);
  assign done_o = (state_q == ST_FIN) && !err_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_iob_uart16550_cfg_seq.sv
// Directed bench for the UART configuration sequencer (TO_W=4).
// Acts as the UART CSR port: programmable ready delay, one-cycle read return.
// Covers nominal, back-pressure, mismatch, timeout, stale inputs, reset and cke.
module tb_iob_uart16550_cfg_seq;

  logic        clk;
  logic        cke;
  logic        rst_n;
  logic        start;
  logic [15:0] div;
  logic [7:0]  lcr, fcr, ier;
  logic        busy, done, err;

  int n_chk  = 0;
  int n_fail = 0;

  iob_uart16550_cfg_seq_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  iob_uart16550_cfg_seq #(
    .ADDR_W(5),
    .DATA_W(32),
    .TO_W  (4)
  ) dut (
    .clk_i  (clk),
    .cke_i  (cke),
    .rst_n_i(rst_n),
    .start_i(start),
    .div_i  (div),
    .lcr_i  (lcr),
    .fcr_i  (fcr),
    .ier_i  (ier),
    .busy_o (busy),
    .done_o (done),
    .err_o  (err),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] exp_addr [7] = '{5'd3, 5'd0, 5'd1, 5'd3, 5'd2, 5'd1, 5'd3};
  logic [3:0] exp_strb [7] = '{4'h8, 4'h1, 4'h2, 4'h8, 4'h4, 4'h2, 4'h0};

  logic [4:0]  g_addr  [8];
  logic [31:0] g_wdata [8];
  logic [3:0]  g_wstrb [8];
  int   n_req, end_cyc, stall_cnt, hold_bad;
  logic end_done, end_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [15:0] d,
                                          input logic [7:0] l, input logic [7:0] f,
                                          input logic [7:0] e);
    case (i)
      0:       return {1'b1, l[6:0]};
      1:       return d[7:0];
      2:       return d[15:8];
      3:       return {1'b0, l[6:0]};
      4:       return f;
      5:       return e;
      default: return 8'h00;
    endcase
  endfunction

  // Start a sequence from IDLE and play the UART side until busy falls.
  // Returns in the first non-busy cycle.
  task automatic run_seq(input int hold, input int stall_step, input logic [7:0] rd_byte,
                         input bit perturb);
    int   wait_n;
    bit   rd_pend;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [3:0]  s0;
    n_req = 0; end_cyc = 0; stall_cnt = 0; hold_bad = 0;
    end_done = 1'b0; end_err = 1'b0;
    wait_n = 0; rd_pend = 1'b0;
    a0 = '0; d0 = '0; s0 = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      bus.rvalid = rd_pend;
      bus.rdata  = rd_pend ? {rd_byte, 24'h5A3C96} : 32'h0;
      rd_pend    = 1'b0;
      if (perturb && c == 2) begin
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hFFFF_FFFF;
      end
      if (perturb && c == 3) begin
        div = 16'hFFFF; lcr = 8'h1F; fcr = 8'h00; ier = 8'h00;
        start = 1'b1;
      end
      if (perturb && c == 4) start = 1'b0;
      if (!busy) begin
        end_cyc  = c;
        end_done = done;
        end_err  = err;
        break;
      end
      bus.ready = 1'b0;
      if (bus.valid) begin
        if (wait_n == 0) begin
          a0 = bus.addr; d0 = bus.wdata; s0 = bus.wstrb;
        end else if (bus.addr !== a0 || bus.wdata !== d0 || bus.wstrb !== s0) begin
          hold_bad++;
        end
        if (n_req == stall_step) stall_cnt++;
        if (wait_n >= hold && n_req != stall_step) begin
          bus.ready = 1'b1;
          if (n_req < 8) begin
            g_addr[n_req]  = bus.addr;
            g_wdata[n_req] = bus.wdata;
            g_wstrb[n_req] = bus.wstrb;
          end
          if (bus.wstrb == 4'h0) rd_pend = 1'b1;
          n_req++;
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end
      tick();
    end
    bus.ready  = 1'b0;
    bus.rvalid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic check_seq(input string tag, input logic [15:0] d, input logic [7:0] l,
                           input logic [7:0] f, input logic [7:0] e);
    chk({tag, " n_req"}, n_req, 7);
    chk({tag, " hold"}, hold_bad, 0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), g_addr[i], exp_addr[i]);
      chk($sformatf("%s wstrb[%0d]", tag, i), g_wstrb[i], exp_strb[i]);
      if (i < 6) chk($sformatf("%s wdata[%0d]", tag, i), g_wdata[i], {4{exp_byte(i, d, l, f, e)}});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cke = 1'b1; start = 1'b0;
    div = 16'h0145; lcr = 8'h03; fcr = 8'h07; ier = 8'h01;
    bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
    repeat (3) tick();

    // Reset values
    chk("rst valid", bus.valid, 0);
    chk("rst busy",  busy, 0);
    chk("rst done",  done, 0);
    chk("rst err",   err, 0);
    chk("rst addr",  bus.addr, 0);
    chk("rst wdata", bus.wdata, 0);
    chk("rst wstrb", bus.wstrb, 0);
    rst_n = 1'b1;
    tick();

    // 1: nominal sequence
    run_seq(0, 99, 8'h03, 1'b0);
    check_seq("nom", 16'h0145, 8'h03, 8'h07, 8'h01);
    chk("nom end_cyc", end_cyc, 9);
    chk("nom done", end_done, 1);
    chk("nom err", end_err, 0);
    // start in FIN is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fin start busy", busy, 0);
    chk("fin start valid", bus.valid, 0);
    tick();

    // 2: back-pressure, 3 wait cycles per request
    run_seq(3, 99, 8'h03, 1'b0);
    check_seq("bp", 16'h0145, 8'h03, 8'h07, 8'h01);
    chk("bp end_cyc", end_cyc, 30);
    chk("bp done", end_done, 1);
    tick();

    // 3: readback mismatch, then a clean restart
    run_seq(0, 99, 8'h83, 1'b0);
    chk("mm end_cyc", end_cyc, 9);
    chk("mm done", end_done, 0);
    chk("mm err", end_err, 1);
    tick(); tick();
    chk("mm err sticky", err, 1);
    chk("mm busy", busy, 0);
    run_seq(0, 99, 8'h03, 1'b0);
    chk("mm2 err", end_err, 0);
    chk("mm2 done", end_done, 1);
    chk("mm2 end_cyc", end_cyc, 9);
    tick();

    // 4: timeout on W_DLM
    run_seq(0, 2, 8'h03, 1'b0);
    chk("to n_req", n_req, 2);
    chk("to wait cycles", stall_cnt, 15);
    chk("to end_cyc", end_cyc, 18);
    chk("to err", end_err, 1);
    chk("to done", end_done, 0);
    chk("to valid", bus.valid, 0);
    chk("to hold", hold_bad, 0);
    chk("to addr0", g_addr[0], 3);
    chk("to addr1", g_addr[1], 0);
    tick();

    // 5: stale start and input changes mid-sequence, stray rvalid
    div = 16'h1234; lcr = 8'h1B; fcr = 8'hC1; ier = 8'h0F;
    run_seq(0, 99, 8'h1B, 1'b1);
    check_seq("stale", 16'h1234, 8'h1B, 8'hC1, 8'h0F);
    chk("stale end_cyc", end_cyc, 9);
    chk("stale done", end_done, 1);
    tick();
    chk("stale no restart", busy, 0);
    div = 16'h0145; lcr = 8'h03; fcr = 8'h07; ier = 8'h01;

    // 6a: reset during W_FCR
    bus.ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("rst mid addr", bus.addr, 2);
    chk("rst mid wstrb", bus.wstrb, 4'h4);
    rst_n = 1'b0;
    tick();
    chk("rst mid valid", bus.valid, 0);
    chk("rst mid busy", busy, 0);
    rst_n = 1'b1;
    bus.ready = 1'b0;
    tick();
    run_seq(0, 99, 8'h03, 1'b0);
    check_seq("rst re", 16'h0145, 8'h03, 8'h07, 8'h01);
    chk("rst re done", end_done, 1);
    tick();

    // 6b: cke low for 5 cycles mid-request
    bus.ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cke pre addr", bus.addr, 3);
    cke = 1'b0;
    bus.ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("cke hold valid %0d", k), bus.valid, 1);
      chk($sformatf("cke hold wdata %0d", k), bus.wdata, 32'h8383_8383);
    end
    chk("cke hold addr", bus.addr, 3);
    chk("cke hold wstrb", bus.wstrb, 4'h8);
    chk("cke hold busy", busy, 1);
    cke = 1'b1;
    tick();
    chk("cke resume addr", bus.addr, 0);
    chk("cke resume wdata", bus.wdata, 32'h4545_4545);
    bus.ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
